// File: rtl/fetch_pkg.sv
// Shared widths, opcodes and state encoding for the instruction fetch controller.
package fetch_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;

  localparam logic [3:0]        HALT_OP = 4'b1111;
  localparam logic [DATA_W-1:0] NOP     = 16'h0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;
endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential fetch with branch redirect, stall,
// halt-on-opcode and a debug read port that borrows the memory outside RUN.
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_opcode,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // RUN   | fetching one word per unstalled cycle
  // HALT  | halt opcode issued, waiting for start

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                instr_valid_q, instr_valid_d;
  logic                dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0]   dbg_data_q, dbg_data_d;
  logic                dbg_grant;

  // The ack cycle blocks a new grant, limiting debug reads to one per two cycles.
  assign dbg_grant = (state_q != S_RUN) && dbg_req && !dbg_ack_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_q       <= NOP;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      dbg_ack_q     <= 1'b0;
      dbg_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      dbg_ack_q     <= dbg_ack_d;
      dbg_data_q    <= dbg_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = 1'b0;
    dbg_ack_d     = dbg_grant;
    dbg_data_d    = dbg_grant ? imem_opcode : dbg_data_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        if (stall) begin
          instr_valid_d = instr_valid_q;
        end else if (br_taken) begin
          // Redirect: the word at the old pc is dropped, giving one bubble.
          pc_d = br_target;
        end else begin
          instr_d       = imem_opcode;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          if (imem_opcode[DATA_W-1 -: 4] == HALT_OP) begin
            state_d = S_HALT;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    imem_addr   = dbg_grant ? dbg_addr : pc_q;
    halted      = (state_q == S_HALT);
    instr       = instr_q;
    instr_pc    = instr_pc_q;
    instr_valid = instr_valid_q;
    dbg_ack     = dbg_ack_q;
    dbg_data    = dbg_data_q;
  end

endmodule
